// File: rtl/mem_req_arbiter.sv
// Serialises OTTER fetch and load/store requests onto the memory_wrapper bus.
// Optional round-robin fetch/data arbitration is enabled with `define MEM_ARB_RR_EN.
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic        MEM_CLK,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_resp,
  output logic [31:0] if_rdata,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_strobe,
  output logic        d_resp,
  output logic [31:0] d_rdata,
  output logic [31:0] MEM_ADDR1,
  output logic        MEM_READ1,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_READ2,
  output logic        MEM_WRITE2,
  output logic [3:0]  strobe,
  input  logic [31:0] MEM_DOUT1,
  input  logic [31:0] MEM_DOUT2,
  input  logic        mem_valid1,
  input  logic        mem_valid2,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    StIdle, StIfBusy, StDrdBusy, StDwrBusy, StIfDone, StDDone
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              load_q, load_d;  // DONE state must capture read data
  logic [1:0]        err_q, err_d;
  logic              if_resp_q, d_resp_q;
  logic [31:0]       if_rdata_q, d_rdata_q;
  logic              pick_data;
  logic              port_valid;

`ifdef MEM_ARB_RR_EN
  logic              last_q, last_d;  // 1: data port granted last

  assign pick_data = (d_rd | d_wr) & (~if_req | ~last_q);
`else
  assign pick_data = d_rd | d_wr;
`endif

  assign port_valid = (state_q == StIfBusy) ? mem_valid1 : mem_valid2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    load_d  = load_q;
    err_d   = err_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (d_rd && d_wr) err_d[0] = 1'b1;
        if (pick_data) begin
          state_d = d_wr ? StDwrBusy : StDrdBusy;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          strb_d  = d_strobe;
`ifdef MEM_ARB_RR_EN
          last_d  = 1'b1;
`endif
        end else if (if_req) begin
          state_d = StIfBusy;
          addr_d  = if_addr;
          wdata_d = '0;
          strb_d  = '0;
`ifdef MEM_ARB_RR_EN
          last_d  = 1'b0;
`endif
        end
      end
      StIfBusy, StDrdBusy, StDwrBusy: begin
        cnt_d = cnt_q + 1'b1;
        // A valid arriving on the expiry cycle still completes the access normally.
        if (port_valid) begin
          state_d = (state_q == StIfBusy) ? StIfDone : StDDone;
          load_d  = (state_q != StDwrBusy);
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d  = (state_q == StIfBusy) ? StIfDone : StDDone;
          load_d   = 1'b0;
          err_d[1] = 1'b1;
        end
      end
      StIfDone, StDDone: state_d = StIdle;
      default:           state_d = StIdle;
    endcase
  end

  always_ff @(posedge MEM_CLK) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      load_q     <= 1'b0;
      err_q      <= '0;
      if_resp_q  <= 1'b0;
      d_resp_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      load_q    <= load_d;
      err_q     <= err_d;
      if_resp_q <= (state_q == StIfDone);
      d_resp_q  <= (state_q == StDDone);
      if (state_q == StIfDone && load_q) if_rdata_q <= MEM_DOUT1;
      if (state_q == StDDone && load_q)  d_rdata_q  <= MEM_DOUT2;
`ifdef MEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign MEM_READ1  = (state_q == StIfBusy);
  assign MEM_READ2  = (state_q == StDrdBusy);
  assign MEM_WRITE2 = (state_q == StDwrBusy);
  assign MEM_ADDR1  = MEM_READ1 ? addr_q : '0;
  assign MEM_ADDR2  = (MEM_READ2 | MEM_WRITE2) ? addr_q : '0;
  assign MEM_DIN2   = MEM_WRITE2 ? wdata_q : '0;
  assign strobe     = (MEM_READ2 | MEM_WRITE2) ? strb_q : '0;
  assign if_resp    = if_resp_q;
  assign d_resp     = d_resp_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: transaction-level model of latency,
// strobes, returned data and sticky error flags, with randomized accesses.
module tb_mem_req_arbiter;

  localparam int unsigned T = 8;

  logic        MEM_CLK = 1'b0;
  logic        rst;
  logic        if_req, d_rd, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_strobe;
  logic        if_resp, d_resp;
  logic [31:0] if_rdata, d_rdata;
  logic [31:0] MEM_ADDR1, MEM_ADDR2, MEM_DIN2;
  logic        MEM_READ1, MEM_READ2, MEM_WRITE2;
  logic [3:0]  strobe;
  logic [31:0] MEM_DOUT1, MEM_DOUT2;
  logic        mem_valid1, mem_valid2;
  logic [1:0]  err;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0] if_rdata_m, d_rdata_m;
  logic [1:0]  err_m;
  bit          last_m;  // 1: data granted last

  mem_req_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .MEM_CLK(MEM_CLK), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_resp(if_resp), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_strobe(d_strobe),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .MEM_ADDR1(MEM_ADDR1), .MEM_READ1(MEM_READ1), .MEM_ADDR2(MEM_ADDR2),
    .MEM_DIN2(MEM_DIN2), .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2), .strobe(strobe),
    .MEM_DOUT1(MEM_DOUT1), .MEM_DOUT2(MEM_DOUT2),
    .mem_valid1(mem_valid1), .mem_valid2(mem_valid2), .err(err)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_strobes"}, 128'({MEM_READ1, MEM_READ2, MEM_WRITE2, if_resp, d_resp}), 128'(0));
    check({tag, "_buses"}, 128'({MEM_ADDR1, MEM_ADDR2, MEM_DIN2, strobe}), 128'(0));
    check({tag, "_regs"}, 128'({if_rdata, d_rdata, err}), 128'({if_rdata_m, d_rdata_m, err_m}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {if_req, d_rd, d_wr, mem_valid1, mem_valid2} = '0;
    repeat (2) @(negedge MEM_CLK);
    rst = 1'b0;
    if_rdata_m = '0;
    d_rdata_m  = '0;
    err_m      = '0;
    last_m     = 1'b0;
  endtask

  // kind: 0 fetch, 1 data read, 2 data write, 3 d_rd+d_wr together.
  // k: cycle in which the matching valid is driven; k outside 1..T means timeout.
  task automatic do_access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int k, input logic [31:0] dout,
                           input bit noise);
    bit   to, busy, is_f, is_w, is_r, last;
    int   kend;
    to   = (k < 1) || (k > int'(T));
    kend = to ? int'(T) : k;
    is_f = (kind == 0);
    is_r = (kind == 1);
    is_w = (kind >= 2);
    @(negedge MEM_CLK);
    {mem_valid1, mem_valid2} = '0;
    if_req   = is_f;
    d_rd     = (kind == 1) || (kind == 3);
    d_wr     = is_w;
    if_addr  = is_f ? addr : $urandom;
    d_addr   = is_f ? $urandom : addr;
    d_wdata  = wdata;
    d_strobe = strb;
    for (int n = 1; n <= kend + 2; n++) begin
      @(negedge MEM_CLK);
      busy = (n <= kend);
      last = (n == kend + 2);
      check("strobes", 128'({MEM_READ1, MEM_READ2, MEM_WRITE2}),
            128'({is_f && busy, is_r && busy, is_w && busy}));
      check("buses", 128'({MEM_ADDR1, MEM_ADDR2, MEM_DIN2, strobe}),
            128'({(is_f && busy) ? addr : 32'h0, (!is_f && busy) ? addr : 32'h0,
                  (is_w && busy) ? wdata : 32'h0, (!is_f && busy) ? strb : 4'h0}));
      check("resp", 128'({if_resp, d_resp}), 128'({is_f && last, !is_f && last}));
      if (last) begin
        if (!to && is_f) if_rdata_m = dout;
        if (!to && is_r) d_rdata_m = dout;
        if (kind == 3) err_m[0] = 1'b1;
        if (to) err_m[1] = 1'b1;
        check("rdata_err", 128'({if_rdata, d_rdata, err}),
              128'({if_rdata_m, d_rdata_m, err_m}));
        {if_req, d_rd, d_wr} = '0;
      end
      mem_valid1 = is_f ? (n == k) : (noise && 1'($urandom_range(0, 1)));
      mem_valid2 = !is_f ? (n == k) : (noise && 1'($urandom_range(0, 1)));
      MEM_DOUT1  = (is_f && n == k + 1) ? dout : $urandom;
      MEM_DOUT2  = (!is_f && n == k + 1) ? dout : $urandom;
    end
  endtask

  initial begin
    {if_req, d_rd, d_wr, mem_valid1, mem_valid2} = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_strobe = '0;
    MEM_DOUT1 = '0; MEM_DOUT2 = '0;
    do_reset();
    check_quiet("reset");

    do_access(0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0);
    do_access(2, 32'h2000, 32'h12345678, 4'b0011, 2, 32'h55AA55AA, 1'b0);
    do_access(1, 32'h3000, 32'h0, 4'hF, 1, 32'hCAFEF00D, 1'b0);
    do_access(3, 32'h4000, 32'hA5A5A5A5, 4'hC, 1, 32'h0BADF00D, 1'b0);
    do_access(1, 32'h5000, 32'h0, 4'hF, int'(T), 32'h13572468, 1'b0);
    do_access(1, 32'h6000, 32'h0, 4'hF, 0, 32'hFFFF0000, 1'b0);
    do_access(0, 32'h7000, 32'h0, 4'h0, 0, 32'h0000FFFF, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_access(int'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(1, 10)), $urandom, 1'b1);
    end

    // Contention: both requests held for four grants.
    do_reset();
    if_req = 1'b1; d_rd = 1'b1; if_addr = 32'h100; d_addr = 32'h2000; d_strobe = 4'hF;
    for (int g = 0; g < 4; g++) begin
      bit          want_d, seen;
      logic [31:0] dv1, dv2;
`ifdef MEM_ARB_RR_EN
      want_d = !last_m;
`else
      want_d = 1'b1;
`endif
      seen = 1'b0;
      for (int w = 0; w < 4 && !seen; w++) begin
        @(negedge MEM_CLK);
        seen = MEM_READ1 | MEM_READ2 | MEM_WRITE2;
      end
      check("grant_seen", 128'(seen), 128'(1));
      if (!seen) break;
      check("grant_port", 128'({MEM_READ1, MEM_READ2}), 128'({!want_d, want_d}));
      dv1 = $urandom; dv2 = $urandom;
      MEM_DOUT1 = dv1; MEM_DOUT2 = dv2;
      mem_valid1 = !want_d; mem_valid2 = want_d;
      @(negedge MEM_CLK);
      {mem_valid1, mem_valid2} = '0;
      @(negedge MEM_CLK);
      if (want_d) d_rdata_m = dv2;
      else if_rdata_m = dv1;
      last_m = want_d;
      check("grant_resp", 128'({if_resp, d_resp}), 128'({!want_d, want_d}));
      check("grant_rdata", 128'({if_rdata, d_rdata}), 128'({if_rdata_m, d_rdata_m}));
      if (g == 3) {if_req, d_rd} = '0;
    end
    {if_req, d_rd} = '0;
    repeat (3) @(negedge MEM_CLK);

    // Reset during the second DRD_BUSY cycle abandons the access.
    d_rd = 1'b1; d_addr = 32'h8000; d_strobe = 4'hF;
    @(negedge MEM_CLK);
    check("mid_busy", 128'({MEM_READ1, MEM_READ2, MEM_WRITE2}), 128'(3'b010));
    @(negedge MEM_CLK);
    rst = 1'b1;
    @(negedge MEM_CLK);
    if_rdata_m = '0; d_rdata_m = '0; err_m = '0;
    check_quiet("mid_reset");
    rst = 1'b0; d_rd = 1'b0; mem_valid2 = 1'b1; MEM_DOUT2 = 32'hBEEFBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge MEM_CLK);
      mem_valid2 = 1'b0;
      check("post_reset", 128'({MEM_READ1, MEM_READ2, MEM_WRITE2, if_resp, d_resp}), 128'(0));
    end
    check("post_reset_regs", 128'({d_rdata, err}), 128'({d_rdata_m, err_m}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits directly upstream of memory_wrapper, between the OTTER fetch and load/store units and the wrapper's two-port memory bus.
- The wrapper shares a single mem_itf, so only one access may be in flight at a time. This block serialises fetch and data requests so that at most one of MEM_READ1, MEM_READ2 and MEM_WRITE2 is high.
- It holds each request stable until mem_valid is seen, captures the registered MEM_DOUT one cycle later, and returns a single-cycle response to the requester.
- It also enforces a per-access watchdog.

Parameters:
- TIMEOUT_CYCLES, 4096, maximum cycles in a BUSY state before the access is abandoned. Must be ≥ 2.
- CNT_W, 13, width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- MEM_CLK  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request, level, sampled only in IDLE.
- if_addr  in  32  fetch address; must be stable while the request is outstanding.
- if_resp  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  32  fetch data, registered, held until the next if_resp.
- d_rd  in  1  data read request, level.
- d_wr  in  1  data write request, level.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_strobe  in  4  byte enables.
- d_resp  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data, registered, held until the next d_resp; unchanged on writes.
- MEM_ADDR1  out  32  to the wrapper instruction port.
- MEM_READ1  out  1
- MEM_ADDR2  out  32  to the wrapper data port.
- MEM_DIN2  out  32
- MEM_READ2  out  1
- MEM_WRITE2  out  1
- strobe  out  4
- MEM_DOUT1  in  32  wrapper registered read data.
- MEM_DOUT2  in  32
- mem_valid1  in  1  wrapper response.
- mem_valid2  in  1
- err  out  2  sticky error flags: [0] d_rd and d_wr both high; [1] watchdog expired. Cleared only by rst.

Behaviour:
- States: IDLE, IF_BUSY, DRD_BUSY, DWR_BUSY, IF_DONE, D_DONE. State is binary-encoded and registered.
- Reset: state=IDLE, counter=0, err=0, if_resp=0, d_resp=0, if_rdata=0, d_rdata=0.
- Reset mid-operation: the access is abandoned, no response pulse is issued, and all MEM_* strobes are low from the next cycle.
- Address, data and strobe latching:
  - On leaving IDLE, the chosen request's address, wdata and strobe are latched into internal registers.
  - MEM_ADDR1, MEM_ADDR2, MEM_DIN2 and strobe drive from these registers, not from the live inputs.
  - Outside the matching BUSY state, address, data and strobe outputs are 0.
- IDLE arbitration (fixed priority, data over fetch):
  - d_wr → DWR_BUSY.
  - else d_rd → DRD_BUSY.
  - else if_req → IF_BUSY.
  - else stay in IDLE.
  - If d_rd and d_wr are both high: set err[0] and treat the access as a write.
- Strobes are decoded from state: MEM_READ1=1 only in IF_BUSY, MEM_READ2=1 only in DRD_BUSY, MEM_WRITE2=1 only in DWR_BUSY. There is never more than one high.
- BUSY exit:
  - IF_BUSY leaves when mem_valid1 is sampled high at a rising edge.
  - DRD_BUSY and DWR_BUSY leave when mem_valid2 is sampled high.
  - The wrapper loads MEM_DOUTx on that same edge.
- Transitions: IF_BUSY → IF_DONE; DRD_BUSY and DWR_BUSY → D_DONE.
- DONE states (one cycle, all MEM_* strobes low):
  - IF_DONE: if_rdata <= MEM_DOUT1, if_resp <= 1.
  - D_DONE: d_rdata <= MEM_DOUT2 for a read only, d_resp <= 1.
  - Next state is always IDLE.
- Latency: request seen in IDLE at cycle 0; strobe high from cycle 1; valid sampled at cycle k; DONE at cycle k+1; resp/rdata visible at cycle k+2. Minimum latency is 3 cycles (k=1).
- Back-to-back: the cycle resp is visible is an IDLE cycle. A request still high then is a new request, so requesters drop req in that cycle unless issuing another.
- Watchdog:
  - The counter clears on entry to any BUSY state and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES before valid: set err[1], go to the DONE state for that port, and issue resp with the data register unchanged.
  - If valid arrives in the same cycle as the timeout, valid wins and err[1] is not set.
- Valid on the non-selected port, or while in IDLE or DONE, is ignored.
- Starvation: fetch can starve under continuous data traffic unless the optional feature below is enabled.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset to fetch) is updated on each IDLE exit.
  - When a data request and if_req are both pending in IDLE, the port not granted last wins.
  - A lone request is granted immediately.
  - The d_rd+d_wr write override and err[0] are unchanged.
- Undefined: fixed data-over-fetch priority and no last_grant register.

Test Plan:
- Fetch read: if_req=1, if_addr=0x100, mem_valid1 high on cycle 3 with wrapper DOUT1=0xDEADBEEF → MEM_READ1 high on cycles 1–3 only; if_resp pulse on cycle 5; if_rdata=0xDEADBEEF; MEM_READ2 and MEM_WRITE2 never high.
- Write: d_wr=1, d_addr=0x2000, d_wdata=0x12345678, d_strobe=4'b0011, valid on cycle 2 → MEM_WRITE2/MEM_ADDR2/MEM_DIN2/strobe held cycles 1–2; d_resp on cycle 4; d_rdata unchanged.
- Contention: if_req and d_rd both high at cycle 0 → data served first.
  - Without MEM_ARB_RR_EN, holding both continuously starves fetch.
  - With MEM_ARB_RR_EN, grants alternate data, fetch, data.
- Protocol error: d_rd=d_wr=1 → write performed, err=2'b01 sticky until rst.
- Timeout: TIMEOUT_CYCLES=8, valid never asserted → err[1]=1, d_resp pulse, then IDLE; MEM_READ2 low after 8 BUSY cycles.
- Reset mid-access: rst in the second DRD_BUSY cycle → the next cycle shows all outputs 0, state IDLE, and no d_resp ever issued for that access.
